// File: rtl/meteor_spawn_scheduler.sv
// meteor_spawn_scheduler: round-robin meteor spawn sequencer with frame cooldown and valid/ack offer
module meteor_spawn_scheduler #(
    parameter int NUM_OBJ      = 4,
    parameter int IDX_W        = 2,
    parameter int SPAWN_FRAMES = 30,
    parameter int X_LIMIT      = 600,
    parameter int FOLD         = 512
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             enable,
    input  logic [NUM_OBJ-1:0] obj_alive,
    input  logic [9:0]       rand_x,
    input  logic [2:0]       rand_x_speed,
    input  logic [2:0]       rand_y_speed,
    input  logic             spawn_ack,
    output logic             spawn_valid,
    output logic [IDX_W-1:0] spawn_idx,
    output logic [9:0]       spawn_x,
    output logic [2:0]       spawn_x_speed,
    output logic [2:0]       spawn_y_speed,
    output logic             busy
);
    typedef enum logic [1:0] {COOLDOWN, SEARCH, SAMPLE, OFFER} state_t;
    state_t state, state_n;
    logic [7:0] cooldown;
    logic [IDX_W-1:0] last_idx, sel_idx, cand;
    logic [IDX_W:0] scan;
    logic found, frame_clk_d, tick;
    assign tick        = frame_clk & ~frame_clk_d;
    assign spawn_valid = state == OFFER;
    assign busy        = !(state == COOLDOWN && cooldown == 8'd0);
    // round-robin scan for the first free slot after last_idx; descending loop so the nearest slot wins
    always_comb begin
        found = 1'b0;
        cand  = '0;
        scan  = '0;
        for (int k = NUM_OBJ; k >= 1; k--) begin
            scan = {1'b0, last_idx} + (IDX_W+1)'(k);
            scan = scan >= (IDX_W+1)'(NUM_OBJ) ? scan - (IDX_W+1)'(NUM_OBJ) : scan;
            if (!obj_alive[scan[IDX_W-1:0]]) begin
                found = 1'b1;
                cand  = scan[IDX_W-1:0];
            end
        end
    end
    // state register
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) state <= COOLDOWN;
        else       state <= state_n;
    // next-state: ack beats a same-cycle alive rise, disable only aborts a search
    always_comb begin
        state_n = state;
        case (state)
            COOLDOWN: state_n = (cooldown == 8'd0 && enable) ? SEARCH : COOLDOWN;
            SEARCH:   state_n = !enable ? COOLDOWN : found ? SAMPLE : SEARCH;
            SAMPLE:   state_n = OFFER;
            OFFER:    state_n = spawn_ack ? COOLDOWN : obj_alive[spawn_idx] ? SEARCH : OFFER;
        endcase
    end
    // frame edge, cooldown counter, slot bookkeeping and payload capture
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_d   <= 1'b0;
            cooldown      <= 8'd0;
            last_idx      <= IDX_W'(NUM_OBJ - 1);
            sel_idx       <= '0;
            spawn_idx     <= '0;
            spawn_x       <= '0;
            spawn_x_speed <= '0;
            spawn_y_speed <= '0;
        end else begin
            frame_clk_d <= frame_clk;
            case (state)
                COOLDOWN: if (enable && tick && cooldown != 8'd0) cooldown <= cooldown - 8'd1;
                SEARCH:   if (found) sel_idx <= cand;
                SAMPLE: begin
                    spawn_idx     <= sel_idx;
                    spawn_x       <= rand_x > 10'(X_LIMIT) ? rand_x - 10'(FOLD) : rand_x;
                    spawn_x_speed <= rand_x_speed;
                    spawn_y_speed <= rand_y_speed == 3'd0 ? 3'd1 : rand_y_speed;
                end
                OFFER: if (spawn_ack) begin
                    last_idx <= spawn_idx;
                    cooldown <= 8'(SPAWN_FRAMES);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_meteor_spawn_scheduler.sv
// tb_meteor_spawn_scheduler: directed stimulus with a scoreboard checking each offered spawn command
module tb_meteor_spawn_scheduler;
    logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, enable = 1'b0, spawn_ack = 1'b0;
    logic [3:0] obj_alive = 4'b0000;
    logic [9:0] rand_x = '0;
    logic [2:0] rand_x_speed = '0, rand_y_speed = '0;
    logic spawn_valid, busy;
    logic [1:0] spawn_idx;
    logic [9:0] spawn_x;
    logic [2:0] spawn_x_speed, spawn_y_speed;
    typedef struct packed {
        logic [1:0] idx;
        logic [9:0] x;
        logic [2:0] xs;
        logic [2:0] ys;
    } exp_t;
    exp_t q[$];
    int n_vec = 0, n_err = 0;
    logic prev_v = 1'b0;
    meteor_spawn_scheduler #(.NUM_OBJ(4), .IDX_W(2), .SPAWN_FRAMES(3), .X_LIMIT(600), .FOLD(512)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .obj_alive(obj_alive),
        .rand_x(rand_x), .rand_x_speed(rand_x_speed), .rand_y_speed(rand_y_speed),
        .spawn_ack(spawn_ack), .spawn_valid(spawn_valid), .spawn_idx(spawn_idx), .spawn_x(spawn_x),
        .spawn_x_speed(spawn_x_speed), .spawn_y_speed(spawn_y_speed), .busy(busy)
    );
    always #5 Clk = ~Clk;
    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask
    // monitor: every new offer must match the oldest expected command
    always @(negedge Clk) begin
        if (spawn_valid && !prev_v) begin
            if (q.size() == 0) chk("unexpected_offer", 1, 0);
            else chk("offer_payload", int'({spawn_idx, spawn_x, spawn_x_speed, spawn_y_speed}), int'(q.pop_front()));
        end
        prev_v = spawn_valid;
    end
    task automatic frame();
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask
    task automatic wait_valid(input int n, input string nm);
        for (int i = 0; i < n && !spawn_valid; i++) @(negedge Clk);
        chk(nm, int'(spawn_valid), 1);
    endtask
    task automatic do_ack();
        spawn_ack = 1'b1;
        @(negedge Clk);
        spawn_ack = 1'b0;
        chk("ack_drop", int'(spawn_valid), 0);
    endtask
    task automatic set_rand(input int x, input int xs, input int ys);
        rand_x = 10'(x);
        rand_x_speed = 3'(xs);
        rand_y_speed = 3'(ys);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int rr_idx[4] = '{1, 2, 3, 0};
        int rr_rx[4]  = '{700, 600, 1023, 5};
        int rr_xs[4]  = '{0, 3, 4, 1};
        int rr_ys[4]  = '{0, 7, 1, 5};
        int rr_ex[4]  = '{188, 600, 511, 5};
        int rr_ey[4]  = '{1, 7, 1, 5};
        int cnt;
        @(negedge Clk);
        chk("reset_valid", int'(spawn_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_payload", int'({spawn_idx, spawn_x, spawn_x_speed, spawn_y_speed}), 0);
        Reset = 1'b0;
        @(negedge Clk);
        set_rand(100, 7, 3);
        q.push_back('{2'd0, 10'd100, 3'd7, 3'd3});
        enable = 1'b1;
        repeat (2) @(negedge Clk);
        chk("latency_not_early", int'(spawn_valid), 0);
        @(negedge Clk);
        chk("latency_3", int'(spawn_valid), 1);
        repeat (5) @(negedge Clk);
        chk("hold_valid", int'(spawn_valid), 1);
        chk("hold_payload", int'({spawn_idx, spawn_x}), int'({2'd0, 10'd100}));
        do_ack();
        chk("cooldown_busy", int'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            set_rand(rr_rx[i], rr_xs[i], rr_ys[i]);
            q.push_back('{2'(rr_idx[i]), 10'(rr_ex[i]), 3'(rr_xs[i]), 3'(rr_ey[i])});
            frame();
            frame();
            repeat (3) @(negedge Clk);
            chk("rr_no_early", int'(spawn_valid), 0);
            frame();
            wait_valid(6, "rr_offer");
            do_ack();
        end
        obj_alive = 4'b1111;
        repeat (3) frame();
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            cnt += int'(spawn_valid);
        end
        chk("full_no_valid", cnt, 0);
        chk("full_busy", int'(busy), 1);
        set_rand(300, 2, 4);
        q.push_back('{2'd2, 10'd300, 3'd2, 3'd4});
        obj_alive = 4'b1011;
        @(negedge Clk);
        chk("release_not_early", int'(spawn_valid), 0);
        @(negedge Clk);
        chk("release_lat2", int'(spawn_valid), 1);
        do_ack();
        obj_alive = 4'b1001;
        set_rand(10, 1, 2);
        q.push_back('{2'd1, 10'd10, 3'd1, 3'd2});
        repeat (3) frame();
        wait_valid(6, "withdraw_offer");
        set_rand(1000, 5, 6);
        q.push_back('{2'd2, 10'd488, 3'd5, 3'd6});
        obj_alive = 4'b1011;
        @(negedge Clk);
        chk("withdraw_drop", int'(spawn_valid), 0);
        wait_valid(3, "withdraw_reoffer");
        spawn_ack = 1'b1;
        obj_alive = 4'b1111;
        @(negedge Clk);
        spawn_ack = 1'b0;
        chk("ack_wins_drop", int'(spawn_valid), 0);
        chk("ack_wins_busy", int'(busy), 1);
        obj_alive = 4'b0000;
        set_rand(42, 6, 2);
        q.push_back('{2'd3, 10'd42, 3'd6, 3'd2});
        cnt = 0;
        frame_clk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            cnt += int'(spawn_valid);
        end
        frame_clk = 1'b0;
        @(negedge Clk);
        frame();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            cnt += int'(spawn_valid);
        end
        chk("held_frame_one_tick", cnt, 0);
        frame();
        wait_valid(6, "cooldown_expire_offer");
        #1 Reset = 1'b1;
        #1;
        chk("reset_async_valid", int'(spawn_valid), 0);
        chk("reset_async_busy", int'(busy), 0);
        enable = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_cooldown_zero", int'(busy), 0);
        set_rand(0, 0, 0);
        q.push_back('{2'd0, 10'd0, 3'd0, 3'd1});
        enable = 1'b1;
        wait_valid(5, "post_reset_offer");
        do_ack();
        repeat (2) @(negedge Clk);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
